// File: rtl/seat_req_pkg.sv
// Shared definitions for the seat request front-end: FSM states,
// Seat_State encodings, keypad command codes and error codes.
package seat_req_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CARD      = 3'd1,
    SEAT_TENS = 3'd2,
    SEAT_ONES = 3'd3,
    CMD       = 3'd4,
    ISSUE     = 3'd5
  } state_t;

  localparam logic [1:0] SS_LEAVE = 2'b00;
  localparam logic [1:0] SS_SIT   = 2'b01;
  localparam logic [1:0] SS_AWAY  = 2'b10;

  localparam logic [3:0] KEY_SIT    = 4'hA;
  localparam logic [3:0] KEY_AWAY   = 4'hB;
  localparam logic [3:0] KEY_LEAVE  = 4'hC;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SEQ     = 3'd1;
  localparam logic [2:0] ERR_KEY     = 3'd2;
  localparam logic [2:0] ERR_RANGE   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ZERO_ID = 3'd5;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_cmd_key(input logic [3:0] k);
    return (k == KEY_SIT) || (k == KEY_AWAY) || (k == KEY_LEAVE);
  endfunction

endpackage

// File: rtl/seat_req_timeout.sv
// Saturating idle-cycle counter for the seat request sequencer.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force the count back to zero (wins over en)
//   en         : count one per cycle while high, saturating at LIMIT
//   expire     : high in the cycle whose edge brings the count to LIMIT
module seat_req_timeout #(
  parameter int unsigned LIMIT = 999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  // Announced one cycle early so the owner's registered err lands on the
  // same edge that the count reaches LIMIT.
  assign expire = en && !clr && (count == W'(LIMIT - 1));

endmodule

// File: rtl/seat_request_ctrl.sv
// Seat request sequencer in front of SchoolSeatingSystem. Collects a
// 4-byte student ID from the card reader and a keypad entry (two seat
// digits, then a command key), validates it and issues one write.
//   clk, rst_n          : clock, asynchronous active-low reset
//   byte_valid/byte_data: card byte strobe, ID bytes MSB first
//   key_valid/key_code  : keypad strobe; 0-9, A sit, B away, C leave, F cancel
//   Student_No/Seat_No/Seat_State : last issued request, held between writes
//   write               : one-cycle request strobe
//   busy                : request in progress (state not IDLE)
//   err/err_code        : one-cycle error strobe, code held until next error
//
// state     | meaning
// IDLE      | waiting for the first card byte; keys ignored
// CARD      | collecting ID bytes 2..4
// SEAT_TENS | waiting for the seat tens digit
// SEAT_ONES | waiting for the seat ones digit
// CMD       | waiting for sit / away / leave
// ISSUE     | write cycle; inputs ignored
module seat_request_ctrl
  import seat_req_pkg::*;
#(
  parameter int unsigned NUM_SEATS   = 24,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [31:0] Student_No,
  output logic [4:0]  Seat_No,
  output logic [1:0]  Seat_State,
  output logic        write,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code
);

  state_t      state, state_nxt;
  logic [31:0] sh_id;
  logic [1:0]  sh_cnt;
  logic [3:0]  sh_tens;
  logic [4:0]  sh_seat;

  logic        cancel;
  logic        expire;
  logic [6:0]  seat_calc;
  logic [1:0]  ss_key;
  logic        err_d;
  logic [2:0]  err_code_d;
  logic        ld_byte, ld_tens, ld_seat;

  assign cancel    = key_valid && (key_code == KEY_CANCEL);
  assign seat_calc = 7'(sh_tens) * 7'd10 + 7'(key_code);

  always_comb begin
    ss_key = SS_LEAVE;
    case (key_code)
      KEY_SIT:  ss_key = SS_SIT;
      KEY_AWAY: ss_key = SS_AWAY;
      default:  ss_key = SS_LEAVE;
    endcase
  end

  seat_req_timeout #(
    .LIMIT(TIMEOUT_CYC - 1)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) || byte_valid || key_valid),
    .en    (state != IDLE),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Priority inside a request: cancel, then any strobe, then timeout.
  always_comb begin
    state_nxt  = state;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    case (state)
      IDLE: begin
        if (byte_valid) state_nxt = CARD;
      end
      CARD: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (key_valid) begin
          state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_SEQ;
        end else if (byte_valid) begin
          if (sh_cnt == 2'd3) begin
            if ({sh_id[31:8], byte_data} == 32'h0) begin
              state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_ZERO_ID;
            end else begin
              state_nxt = SEAT_TENS;
            end
          end
        end else if (expire) begin
          state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_TIMEOUT;
        end
      end
      SEAT_TENS, SEAT_ONES, CMD: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (byte_valid) begin
          state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_SEQ;
        end else if (key_valid) begin
          if (state == SEAT_TENS) begin
            if (is_digit(key_code)) state_nxt = SEAT_ONES;
            else begin state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_KEY; end
          end else if (state == SEAT_ONES) begin
            if (!is_digit(key_code)) begin
              state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_KEY;
            end else if (seat_calc >= 7'(NUM_SEATS)) begin
              state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_RANGE;
            end else begin
              state_nxt = CMD;
            end
          end else begin
            if (is_cmd_key(key_code)) state_nxt = ISSUE;
            else begin state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_KEY; end
          end
        end else if (expire) begin
          state_nxt = IDLE; err_d = 1'b1; err_code_d = ERR_TIMEOUT;
        end
      end
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = byte_valid && (((state == IDLE) && (state_nxt == CARD)) ||
                             ((state == CARD) && (state_nxt != IDLE)));
    ld_tens = (state == SEAT_TENS) && (state_nxt == SEAT_ONES);
    ld_seat = (state == SEAT_ONES) && (state_nxt == CMD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_id   <= '0;
      sh_cnt  <= '0;
      sh_tens <= '0;
      sh_seat <= '0;
    end else begin
      if (ld_byte) begin
        if (state == IDLE) begin
          sh_id  <= {byte_data, 24'h0};
          sh_cnt <= 2'd1;
        end else begin
          case (sh_cnt)
            2'd1:    sh_id[23:16] <= byte_data;
            2'd2:    sh_id[15:8]  <= byte_data;
            default: sh_id[7:0]   <= byte_data;
          endcase
          sh_cnt <= sh_cnt + 2'd1;
        end
      end
      if (ld_tens) sh_tens <= key_code;
      if (ld_seat) sh_seat <= seat_calc[4:0];
    end
  end

  // The command key is the last piece of the request, so it feeds
  // Seat_State directly on the edge that enters ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Student_No <= '0;
      Seat_No    <= '0;
      Seat_State <= SS_LEAVE;
      write      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      write <= (state_nxt == ISSUE);
      busy  <= (state_nxt != IDLE);
      err   <= err_d;
      if (err_d) err_code <= err_code_d;
      if (state_nxt == ISSUE) begin
        Student_No <= sh_id;
        Seat_No    <= sh_seat;
        Seat_State <= ss_key;
      end
    end
  end

endmodule

// File: tb/tb_seat_request_ctrl.sv
module tb_seat_request_ctrl;

  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [31:0] Student_No;
  logic [4:0]  Seat_No;
  logic [1:0]  Seat_State;
  logic        write;
  logic        busy;
  logic        err;
  logic [2:0]  err_code;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seat_request_ctrl #(.NUM_SEATS(24), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .key_valid (key_valid),
    .key_code  (key_code),
    .Student_No(Student_No),
    .Seat_No   (Seat_No),
    .Seat_State(Seat_State),
    .write     (write),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  // Inputs change on the falling edge; results are read on the next one.
  task send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task send_key(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task send_id(input logic [31:0] id);
    send_byte(id[31:24]); send_byte(id[23:16]);
    send_byte(id[15:8]);  send_byte(id[7:0]);
  endtask

  task test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
    total++; if (write !== 1'b0) $display("FAIL reset_write got %0b exp 0", write); else passed++;
    total++; if (err !== 1'b0 || err_code !== 3'd0) $display("FAIL reset_err got %0b/%0d exp 0/0", err, err_code); else passed++;
    total++; if (Student_No !== 32'h0 || Seat_No !== 5'd0 || Seat_State !== 2'd0)
      $display("FAIL reset_data got %h/%0d/%0d exp 0/0/0", Student_No, Seat_No, Seat_State); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_basic;
    send_id(32'h12345678);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %0b exp 1", busy); else passed++;
    send_key(4'd1); send_key(4'd7);
    total++; if (write !== 1'b0) $display("FAIL basic_early_write got %0b exp 0", write); else passed++;
    send_key(4'hA);
    total++; if (write !== 1'b1) $display("FAIL basic_write got %0b exp 1", write); else passed++;
    total++; if (Student_No !== 32'h12345678) $display("FAIL basic_id got %h exp 12345678", Student_No); else passed++;
    total++; if (Seat_No !== 5'd17 || Seat_State !== 2'b01) $display("FAIL basic_seat got %0d/%0d exp 17/1", Seat_No, Seat_State); else passed++;
    total++; if (err !== 1'b0) $display("FAIL basic_err got %0b exp 0", err); else passed++;
    @(negedge clk);
    total++; if (write !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after got w%0b b%0b exp w0 b0", write, busy); else passed++;
  endtask

  task test_range;
    send_id(32'hAABBCCDD);
    send_key(4'd2); send_key(4'd5);
    total++; if (err !== 1'b1 || err_code !== 3'd3) $display("FAIL range25_err got %0b/%0d exp 1/3", err, err_code); else passed++;
    total++; if (write !== 1'b0 || busy !== 1'b0) $display("FAIL range25_state got w%0b b%0b exp w0 b0", write, busy); else passed++;
    total++; if (Student_No !== 32'h12345678 || Seat_No !== 5'd17) $display("FAIL range25_hold got %h/%0d exp 12345678/17", Student_No, Seat_No); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b0 || err_code !== 3'd3) $display("FAIL range_pulse got %0b/%0d exp 0/3", err, err_code); else passed++;
    send_id(32'h01020304);
    send_key(4'd2); send_key(4'd3); send_key(4'hC);
    total++; if (write !== 1'b1 || Seat_No !== 5'd23 || Seat_State !== 2'b00)
      $display("FAIL range23 got w%0b %0d/%0d exp w1 23/0", write, Seat_No, Seat_State); else passed++;
    @(negedge clk);
    send_id(32'h01020304);
    send_key(4'd2); send_key(4'd4);
    total++; if (err !== 1'b1 || busy !== 1'b0 || write !== 1'b0) $display("FAIL range24 got e%0b b%0b w%0b exp e1 b0 w0", err, busy, write); else passed++;
  endtask

  task test_zero_id;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    total++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL zero_partial got b%0b e%0b exp b1 e0", busy, err); else passed++;
    send_byte(8'h00);
    total++; if (err !== 1'b1 || err_code !== 3'd5 || busy !== 1'b0) $display("FAIL zero_err got e%0b c%0d b%0b exp e1 c5 b0", err, err_code, busy); else passed++;
    send_id(32'hDEADBEEF);
    send_key(4'd0); send_key(4'd9); send_key(4'hB);
    total++; if (write !== 1'b1 || Student_No !== 32'hDEADBEEF || Seat_No !== 5'd9 || Seat_State !== 2'b10)
      $display("FAIL zero_next got w%0b %h/%0d/%0d exp w1 deadbeef/9/2", write, Student_No, Seat_No, Seat_State); else passed++;
    send_byte(8'h55);  // lands in the ISSUE cycle
    @(negedge clk);
    total++; if (busy !== 1'b0 || write !== 1'b0) $display("FAIL issue_byte got b%0b w%0b exp b0 w0", busy, write); else passed++;
  endtask

  task test_seq_key;
    send_key(4'd5); send_key(4'hF);
    total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL idle_key got b%0b e%0b exp b0 e0", busy, err); else passed++;
    send_id(32'h0000_0001);
    send_key(4'hD);
    total++; if (err !== 1'b1 || err_code !== 3'd2) $display("FAIL tens_keyD got %0b/%0d exp 1/2", err, err_code); else passed++;
    send_byte(8'h12); send_key(4'd3);
    total++; if (err !== 1'b1 || err_code !== 3'd1) $display("FAIL card_key got %0b/%0d exp 1/1", err, err_code); else passed++;
    send_id(32'h0000_0002);
    send_key(4'd1); send_key(4'd2); send_key(4'd3);
    total++; if (err !== 1'b1 || err_code !== 3'd2 || write !== 1'b0) $display("FAIL cmd_digit got %0b/%0d w%0b exp 1/2 w0", err, err_code, write); else passed++;
    send_id(32'h0000_0003);
    send_key(4'd1); send_byte(8'h09);
    total++; if (err !== 1'b1 || err_code !== 3'd1) $display("FAIL ones_byte got %0b/%0d exp 1/1", err, err_code); else passed++;
    send_id(32'h0000_0004);
    send_key(4'd1); send_key(4'hE);
    total++; if (err !== 1'b1 || err_code !== 3'd2) $display("FAIL ones_keyE got %0b/%0d exp 1/2", err, err_code); else passed++;
    // Simultaneous strobes: IDLE takes the byte, CARD honours cancel.
    byte_valid = 1'b1; byte_data = 8'h77; key_valid = 1'b1; key_code = 4'hF;
    @(negedge clk);
    total++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL simul_idle got b%0b e%0b exp b1 e0", busy, err); else passed++;
    @(negedge clk);
    byte_valid = 1'b0; key_valid = 1'b0;
    total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL simul_card_cancel got b%0b e%0b exp b0 e0", busy, err); else passed++;
    send_id(32'h0000_0005);
    byte_valid = 1'b1; byte_data = 8'h01; key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    byte_valid = 1'b0; key_valid = 1'b0;
    total++; if (err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) $display("FAIL simul_tens got e%0b c%0d b%0b exp e1 c1 b0", err, err_code, busy); else passed++;
  endtask

  task test_timeout;
    int first_err;
    logic busy_before;
    first_err = 0;
    busy_before = 1'b0;
    send_id(32'h01020304);
    send_key(4'd0);
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (i == int'(TO) - 2) busy_before = busy;
      if (err && first_err == 0) first_err = i;
    end
    total++; if (first_err != int'(TO) - 1) $display("FAIL timeout_cycle got %0d exp %0d", first_err, TO - 1); else passed++;
    total++; if (busy_before !== 1'b1) $display("FAIL timeout_busy_before got %0b exp 1", busy_before); else passed++;
    total++; if (busy !== 1'b0 || err_code !== 3'd4 || write !== 1'b0) $display("FAIL timeout_end got b%0b c%0d w%0b exp b0 c4 w0", busy, err_code, write); else passed++;
  endtask

  task test_cancel;
    send_id(32'h0A0B0C0D);
    send_key(4'd0); send_key(4'd3); send_key(4'hF);
    total++; if (busy !== 1'b0 || err !== 1'b0 || write !== 1'b0) $display("FAIL cancel got b%0b e%0b w%0b exp b0 e0 w0", busy, err, write); else passed++;
    // Cancel arriving in the very cycle the timeout would fire.
    send_id(32'h0A0B0C0D);
    send_key(4'd0);
    repeat (TO - 2) @(negedge clk);
    total++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL cancel_to_pre got b%0b e%0b exp b1 e0", busy, err); else passed++;
    send_key(4'hF);
    total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL cancel_to got b%0b e%0b exp b0 e0", busy, err); else passed++;
  endtask

  task test_mid_reset;
    send_byte(8'h11); send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || write !== 1'b0 || err !== 1'b0 || err_code !== 3'd0)
      $display("FAIL midrst_ctrl got b%0b w%0b e%0b c%0d exp all 0", busy, write, err, err_code); else passed++;
    total++; if (Student_No !== 32'h0 || Seat_No !== 5'd0 || Seat_State !== 2'd0)
      $display("FAIL midrst_data got %h/%0d/%0d exp 0/0/0", Student_No, Seat_No, Seat_State); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_id(32'hCAFE0123);
    send_key(4'd0); send_key(4'd5); send_key(4'hA);
    total++; if (write !== 1'b1 || Student_No !== 32'hCAFE0123 || Seat_No !== 5'd5 || Seat_State !== 2'b01)
      $display("FAIL midrst_after got w%0b %h/%0d/%0d exp w1 cafe0123/5/1", write, Student_No, Seat_No, Seat_State); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_zero_id();
    test_seq_key();
    test_timeout();
    test_cancel();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
